// File: rtl/sisc_exec_ctrl_if.sv
// sisc_exec_ctrl_if: instruction/operand bus between the SISC datapath and its execution core.
// Carries the held instruction word, register read data and PC+1 in, and the ALU result,
// branch target, status flags and all datapath control strobes out. No clock or reset inside.
interface sisc_exec_ctrl_if;
    // Datapath -> core
    logic [31:0] ir;          // instruction word, stable FETCH..WB
    logic [31:0] rsa;         // register read data for rs
    logic [31:0] rsb;         // register read data for rt
    logic [15:0] pc_inc;      // current PC + 1

    // Core -> datapath
    logic [31:0] alu_result;  // combinational ALU result
    logic [15:0] br_addr;     // branch target
    logic [3:0]  stat;        // status register {C,N,V,Z}
    logic        rf_we;       // register-file write enable
    logic        wb_sel;      // 1 = memory data, 0 = ALU data to write-back
    logic        rd_sel;      // 1 = rt, 0 = rd as destination
    logic        mm_sel;      // 1 = imm, 0 = alu_result[15:0] as memory address
    logic        dm_we;       // data-memory write enable
    logic        br_sel;      // 1 = relative target, 0 = absolute
    logic        pc_sel;      // 1 = load br_addr, 0 = load pc_inc
    logic        pc_write;    // PC load enable
    logic        pc_rst;      // PC clear
    logic        halted;      // core is in HALT

    // Datapath / environment side
    modport master (
        output ir, rsa, rsb, pc_inc,
        input  alu_result, br_addr, stat, rf_we, wb_sel, rd_sel, mm_sel,
               dm_we, br_sel, pc_sel, pc_write, pc_rst, halted
    );

    // Execution-core side
    modport slave (
        input  ir, rsa, rsb, pc_inc,
        output alu_result, br_addr, stat, rf_we, wb_sel, rd_sel, mm_sel,
               dm_we, br_sel, pc_sel, pc_write, pc_rst, halted
    );
endinterface

// File: rtl/sisc_exec_ctrl.sv
// sisc_exec_ctrl: SISC execution core - 5-cycle sequencing FSM, 32-bit ALU with {C,N,V,Z} status, branch-target adder.
// Latency: one instruction per 5 cycles (FETCH..WB) after a 2-cycle START; alu_result/br_addr are combinational.
// Backpressure: none - the FSM free-runs; HALT is held until rst_f. Ports: clk, rst_f (async, active-high), bus (slave).
// Optional feature macro SISC_SHIFT_EN: when defined funct 6/7 shift left/right logically by rsb[4:0];
// when undefined they pass rsa like funct 8-F and no shifter is built.
module sisc_exec_ctrl (
    input  logic               clk,
    input  logic               rst_f,
    sisc_exec_ctrl_if.slave    bus
);

    // ------------------------------------------------------------------
    // Opcode / function encodings
    // ------------------------------------------------------------------
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_LOD  = 4'h3;
    localparam logic [3:0] OP_STR  = 4'h4;
    localparam logic [3:0] OP_BRA  = 4'h5;
    localparam logic [3:0] OP_BRR  = 4'h6;
    localparam logic [3:0] OP_BNE  = 4'h7;
    localparam logic [3:0] OP_BNR  = 4'h8;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [3:0] FN_ADD  = 4'h0;
    localparam logic [3:0] FN_SUB  = 4'h1;
    localparam logic [3:0] FN_AND  = 4'h2;
    localparam logic [3:0] FN_OR   = 4'h3;
    localparam logic [3:0] FN_XOR  = 4'h4;
    localparam logic [3:0] FN_NOT  = 4'h5;
`ifdef SISC_SHIFT_EN
    localparam logic [3:0] FN_SHL  = 4'h6;
    localparam logic [3:0] FN_SHR  = 4'h7;
`endif

    typedef enum logic [2:0] {
        S_START0 = 3'd0,
        S_START1 = 3'd1,
        S_FETCH  = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_MEM    = 3'd5,
        S_WB     = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    // ------------------------------------------------------------------
    // Instruction field decode
    // ------------------------------------------------------------------
    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic [15:0] imm;
    logic [3:0]  funct;
    logic [31:0] imm_sext;

    assign opcode   = bus.ir[31:28];
    assign mm       = bus.ir[27:24];
    assign imm      = bus.ir[15:0];
    assign funct    = bus.ir[3:0];
    assign imm_sext = {{16{imm[15]}}, imm};

    // rs/rt/rd select register-file ports outside this block.
    logic unused_reg_fields;
    assign unused_reg_fields = ^bus.ir[23:16];

    logic is_mem_op;    // LOD or STR
    logic is_imm_add;   // opcodes whose ALU op is forced to rsa + sext(imm)
    logic upd_stat;     // opcodes that load the status register
    logic writes_rf;
    logic br_sel_dec;

    assign is_mem_op  = (opcode == OP_LOD) || (opcode == OP_STR);
    assign is_imm_add = (opcode == OP_ADDI) || is_mem_op;
    assign upd_stat   = (opcode == OP_ALU) || (opcode == OP_ADDI);
    assign writes_rf  = (opcode == OP_ALU) || (opcode == OP_ADDI) || (opcode == OP_LOD);
    assign br_sel_dec = (opcode == OP_BRR) || (opcode == OP_BNR);

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [3:0]  alu_fn;
    logic [31:0] op_b;
    logic [31:0] add_b;
    logic [32:0] sum33;
    logic [31:0] res;
    logic        flag_c;
    logic        flag_v;
    logic [3:0]  stat_d;

    always_comb begin
        alu_fn = funct;
        op_b   = bus.rsb;
        if (is_imm_add) begin
            alu_fn = FN_ADD;
            op_b   = imm_sext;
        end

        // Subtract shares the adder: rsa + ~rsb + 1, so C is "no borrow".
        add_b = (alu_fn == FN_SUB) ? ~op_b : op_b;
        sum33 = {1'b0, bus.rsa} + {1'b0, add_b} + {32'd0, (alu_fn == FN_SUB)};

        res    = bus.rsa;
        flag_c = 1'b0;
        flag_v = 1'b0;
        case (alu_fn)
            FN_ADD, FN_SUB: begin
                res    = sum33[31:0];
                flag_c = sum33[32];
                // Overflow: both adder inputs share a sign that the sum lacks.
                flag_v = (bus.rsa[31] == add_b[31]) && (sum33[31] != bus.rsa[31]);
            end
            FN_AND: res = bus.rsa & op_b;
            FN_OR:  res = bus.rsa | op_b;
            FN_XOR: res = bus.rsa ^ op_b;
            FN_NOT: res = ~bus.rsa;
`ifdef SISC_SHIFT_EN
            FN_SHL: res = bus.rsa << bus.rsb[4:0];
            FN_SHR: res = bus.rsa >> bus.rsb[4:0];
`endif
            default: res = bus.rsa;
        endcase

        stat_d = {flag_c, res[31], flag_v, (res == 32'd0)};
    end

    assign bus.alu_result = res;

    // ------------------------------------------------------------------
    // Branch target and decision
    // ------------------------------------------------------------------
    assign bus.br_addr = br_sel_dec ? (bus.pc_inc + imm) : imm;

    logic [3:0] stat_q;
    logic       cond_hit;
    logic       br_taken;

    // Evaluated in MEM, where stat_q already holds this instruction's EXEC update,
    // so the registered WB strobe sees the same flags as WB would.
    assign cond_hit = |(mm & stat_q);

    always_comb begin
        br_taken = 1'b0;
        case (opcode)
            OP_BRA, OP_BRR: br_taken = cond_hit;
            OP_BNE, OP_BNR: br_taken = ~cond_hit;
            default:        br_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencing FSM with registered strobes
    // ------------------------------------------------------------------
    state_t state_q;
    logic   rf_we_q;
    logic   wb_sel_q;
    logic   rd_sel_q;
    logic   mm_sel_q;
    logic   dm_we_q;
    logic   br_sel_q;
    logic   pc_sel_q;
    logic   pc_write_q;
    logic   pc_rst_q;
    logic   halted_q;

    // Each strobe is computed on the transition into the state that owns it,
    // so outputs are glitch-free flops and reset kills any in-flight write.
    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            state_q    <= S_START0;
            stat_q     <= 4'd0;
            rf_we_q    <= 1'b0;
            wb_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            mm_sel_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            br_sel_q   <= 1'b0;
            pc_sel_q   <= 1'b0;
            pc_write_q <= 1'b0;
            pc_rst_q   <= 1'b1;
            halted_q   <= 1'b0;
        end else begin
            rf_we_q    <= 1'b0;
            wb_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            mm_sel_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            br_sel_q   <= 1'b0;
            pc_sel_q   <= 1'b0;
            pc_write_q <= 1'b0;
            pc_rst_q   <= 1'b0;
            halted_q   <= 1'b0;

            case (state_q)
                S_START0: begin
                    state_q  <= S_START1;
                    pc_rst_q <= 1'b1;
                end
                S_START1: state_q <= S_FETCH;
                S_FETCH:  state_q <= S_DECODE;
                S_DECODE: begin
                    if (opcode == OP_HLT) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_q <= S_MEM;
                    if (upd_stat) begin
                        stat_q <= stat_d;
                    end
                    dm_we_q  <= (opcode == OP_STR);
                    mm_sel_q <= is_mem_op & mm[0];
                end
                S_MEM: begin
                    state_q    <= S_WB;
                    pc_write_q <= 1'b1;
                    pc_sel_q   <= br_taken;
                    br_sel_q   <= br_sel_dec;
                    rf_we_q    <= writes_rf;
                    rd_sel_q   <= (opcode == OP_ADDI) || (opcode == OP_LOD);
                    wb_sel_q   <= (opcode == OP_LOD);
                    // Load keeps the address mux steady while memory data is written back.
                    mm_sel_q   <= (opcode == OP_LOD) & mm[0];
                end
                S_WB: state_q <= S_FETCH;
                S_HALT: begin
                    state_q  <= S_HALT;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= S_START0;
                    pc_rst_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.stat     = stat_q;
    assign bus.rf_we    = rf_we_q;
    assign bus.wb_sel   = wb_sel_q;
    assign bus.rd_sel   = rd_sel_q;
    assign bus.mm_sel   = mm_sel_q;
    assign bus.dm_we    = dm_we_q;
    assign bus.br_sel   = br_sel_q;
    assign bus.pc_sel   = pc_sel_q;
    assign bus.pc_write = pc_write_q;
    assign bus.pc_rst   = pc_rst_q;
    assign bus.halted   = halted_q;

    logic unused_nop;
    assign unused_nop = (OP_NOP == 4'h0);

endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// tb_sisc_exec_ctrl: directed bench for sisc_exec_ctrl with a write-back / memory scoreboard.
// Stimulus pushes hand-computed expectations; a negedge monitor pops them on pc_write / dm_we.
// Ports: none (top-level bench).
module tb_sisc_exec_ctrl;

    logic clk;
    logic rst_f;

    sisc_exec_ctrl_if bus();

    sisc_exec_ctrl dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected write-back record; strb = {rf_we, wb_sel, rd_sel, mm_sel, pc_sel, br_sel}
    typedef struct packed {
        logic [31:0] alu;
        logic        chk_alu;
        logic [15:0] br;
        logic [3:0]  st;
        logic [5:0]  strb;
    } wb_exp_t;

    typedef struct packed {
        logic [31:0] alu;
        logic        mm_sel;
    } mem_exp_t;

    wb_exp_t  wb_q[$];
    mem_exp_t mem_q[$];

    int n_chk  = 0;
    int n_fail = 0;
    int wb_idx = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic exp_wb(input logic [31:0] alu, input logic chk_alu, input logic [15:0] br,
                          input logic [3:0] st, input logic [5:0] strb);
        wb_exp_t e;
        e.alu = alu; e.chk_alu = chk_alu; e.br = br; e.st = st; e.strb = strb;
        wb_q.push_back(e);
    endtask

    task automatic exp_mem(input logic [31:0] alu, input logic mm_sel);
        mem_exp_t e;
        e.alu = alu; e.mm_sel = mm_sel;
        mem_q.push_back(e);
    endtask

    // Monitor: consumes expectations whenever the DUT presents a WB or store strobe.
    always @(negedge clk) begin
        if (!rst_f) begin
            if (bus.pc_write) begin
                if (wb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_wb: pc_write=1, expected no write-back (t=%0t)", $time);
                end else begin
                    wb_exp_t e;
                    e = wb_q.pop_front();
                    chk($sformatf("wb%0d_strobes", wb_idx),
                        32'({bus.rf_we, bus.wb_sel, bus.rd_sel, bus.mm_sel, bus.pc_sel, bus.br_sel}),
                        32'(e.strb));
                    chk($sformatf("wb%0d_stat", wb_idx), 32'(bus.stat), 32'(e.st));
                    chk($sformatf("wb%0d_br_addr", wb_idx), 32'(bus.br_addr), 32'(e.br));
                    if (e.chk_alu)
                        chk($sformatf("wb%0d_alu", wb_idx), bus.alu_result, e.alu);
                    wb_idx++;
                end
            end
            if (bus.dm_we) begin
                if (mem_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_store: dm_we=1, expected no store (t=%0t)", $time);
                end else begin
                    mem_exp_t m;
                    m = mem_q.pop_front();
                    chk("store_addr_alu", bus.alu_result, m.alu);
                    chk("store_mm_sel", 32'(bus.mm_sel), 32'(m.mm_sel));
                end
            end
        end
    end

    // Runs one instruction from FETCH entry to the next FETCH, checking strobe timing per cycle.
    task automatic run(input logic [31:0] ir_v, input logic [31:0] rsa_v,
                       input logic [31:0] rsb_v, input logic [15:0] pc_v);
        logic [3:0] op;
        op = ir_v[31:28];
        bus.ir = ir_v; bus.rsa = rsa_v; bus.rsb = rsb_v; bus.pc_inc = pc_v;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            chk("pc_write_timing", 32'(bus.pc_write), 32'(k == 4));
            chk("dm_we_timing", 32'(bus.dm_we), 32'((k == 3) && (op == 4'h4)));
            chk("rf_we_timing", 32'(bus.rf_we), 32'((k == 4) && (op >= 4'h1) && (op <= 4'h3)));
        end
    endtask

    // Releases reset at a negedge and walks START0/START1 into FETCH.
    task automatic release_reset();
        @(negedge clk);
        rst_f = 1'b0;
        @(posedge clk); #1;
        chk("start1_pc_rst", 32'(bus.pc_rst), 32'd1);
        @(posedge clk); #1;
        chk("fetch_pc_rst", 32'(bus.pc_rst), 32'd0);
        chk("fetch_pc_write", 32'(bus.pc_write), 32'd0);
    endtask

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_ALU  = 6'b100000;
    localparam logic [5:0] S_ADDI = 6'b101000;
    localparam logic [5:0] S_LOD0 = 6'b111000;
    localparam logic [5:0] S_LOD1 = 6'b111100;

    initial begin
        rst_f = 1'b1;
        bus.ir = 32'd0; bus.rsa = 32'd0; bus.rsb = 32'd0; bus.pc_inc = 16'd0;
        #1;
        chk("rst_pc_rst", 32'(bus.pc_rst), 32'd1);
        chk("rst_stat", 32'(bus.stat), 32'd0);
        chk("rst_strobes", 32'({bus.rf_we, bus.wb_sel, bus.rd_sel, bus.mm_sel, bus.dm_we,
                                bus.br_sel, bus.pc_sel, bus.pc_write, bus.halted}), 32'd0);
        @(negedge clk);
        release_reset();

        // ADD signed overflow: 0x7FFFFFFF + 1
        exp_wb(32'h8000_0000, 1'b1, 16'h0000, 4'b0110, S_ALU);
        run(32'h1000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 16'h0001);
        // SUB equal operands: zero with carry (no borrow)
        exp_wb(32'h0000_0000, 1'b1, 16'h0001, 4'b1001, S_ALU);
        run(32'h1000_0001, 32'd5, 32'd5, 16'h0002);
        // BRA mm=0001 on Z=1: taken, absolute
        exp_wb(32'd0, 1'b0, 16'h0040, 4'b1001, 6'b000010);
        run(32'h5100_0040, 32'd0, 32'd0, 16'h0003);
        // ADDI 1 + 1
        exp_wb(32'h0000_0002, 1'b1, 16'h0001, 4'b0000, S_ADDI);
        run(32'h2000_0001, 32'd1, 32'd0, 16'h0004);
        // BNR mm=0001 on Z=0: taken, relative with wrap
        exp_wb(32'd0, 1'b0, 16'h000E, 4'b0000, 6'b000011);
        run(32'h8100_FFFE, 32'd0, 32'd0, 16'h0010);
        // BRR mm=0: never taken, target still relative
        exp_wb(32'd0, 1'b0, 16'h0014, 4'b0000, 6'b000001);
        run(32'h6000_0004, 32'd0, 32'd0, 16'h0010);
        // ADDI with negative immediate
        exp_wb(32'hFFFF_FFFF, 1'b1, 16'hFFFF, 4'b0100, S_ADDI);
        run(32'h2000_FFFF, 32'd0, 32'd0, 16'h0011);
        // STR absolute address: store in MEM only, stat untouched
        exp_mem(32'h0000_0120, 1'b1);
        exp_wb(32'h0000_0120, 1'b1, 16'h0020, 4'b0100, S_NONE);
        run(32'h4100_0020, 32'h0000_0100, 32'h0000_DEAD, 16'h0012);
        // LOD rsa + sext(imm)
        exp_wb(32'h0000_0007, 1'b1, 16'h0003, 4'b0100, S_LOD0);
        run(32'h3000_0003, 32'd4, 32'd0, 16'h0013);
        // LOD absolute: mm_sel held through WB
        exp_wb(32'h0000_0010, 1'b1, 16'h0010, 4'b0100, S_LOD1);
        run(32'h3100_0010, 32'd0, 32'd0, 16'h0014);
        // ADD with carry out to zero
        exp_wb(32'h0000_0000, 1'b1, 16'h0000, 4'b1001, S_ALU);
        run(32'h1000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 16'h0015);
        // BNE mm=0: always taken
        exp_wb(32'd0, 1'b0, 16'h0123, 4'b1001, 6'b000010);
        run(32'h7000_0123, 32'd0, 32'd0, 16'h0016);
        // NOT
        exp_wb(32'hFFFF_FFFF, 1'b1, 16'h0005, 4'b0100, S_ALU);
        run(32'h1000_0005, 32'd0, 32'd0, 16'h0017);
        // XOR
        exp_wb(32'h0F0F_0F0F, 1'b1, 16'h0004, 4'b0000, S_ALU);
        run(32'h1000_0004, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 16'h0018);
        // SHL 1 by 4 (pass rsa when the shifter is not built)
`ifdef SISC_SHIFT_EN
        exp_wb(32'h0000_0010, 1'b1, 16'h0006, 4'b0000, S_ALU);
`else
        exp_wb(32'h0000_0001, 1'b1, 16'h0006, 4'b0000, S_ALU);
`endif
        run(32'h1000_0006, 32'd1, 32'd4, 16'h0019);
        // BRA mm=0100 with N=0: not taken
        exp_wb(32'd0, 1'b0, 16'h0055, 4'b0000, S_NONE);
        run(32'h5400_0055, 32'd0, 32'd0, 16'h001A);

        // HLT: halted from DECODE onward, no further PC writes
        bus.ir = 32'hF000_0000;
        @(posedge clk); #1;
        chk("decode_halted", 32'(bus.halted), 32'd0);
        @(posedge clk); #1;
        chk("halt_halted", 32'(bus.halted), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("halt_held", 32'({bus.halted, bus.pc_write}), 32'b10);
        end

        // Reset out of HALT, run one ADD so stat is non-zero
        rst_f = 1'b1;
        #1;
        chk("halt_rst_halted", 32'(bus.halted), 32'd0);
        release_reset();
        exp_wb(32'h8000_0000, 1'b1, 16'h0000, 4'b0110, S_ALU);
        run(32'h1000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 16'h0001);

        // Abort an ADD with reset during EXEC
        bus.ir = 32'h1000_0000; bus.rsa = 32'hFFFF_FFFF; bus.rsb = 32'h1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("exec_stat_before_rst", 32'(bus.stat), 32'b0110);
        rst_f = 1'b1;
        #1;
        chk("abort_stat", 32'(bus.stat), 32'd0);
        chk("abort_pc_rst", 32'(bus.pc_rst), 32'd1);
        chk("abort_strobes", 32'({bus.rf_we, bus.dm_we, bus.pc_write}), 32'd0);
        repeat (3) @(posedge clk);
        release_reset();
        chk("restart_stat", 32'(bus.stat), 32'd0);

        // NOP after restart
        exp_wb(32'd0, 1'b0, 16'h0000, 4'b0000, S_NONE);
        run(32'h0000_0000, 32'd0, 32'd0, 16'h0001);

        @(negedge clk);
        chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        chk("mem_queue_drained", 32'(mem_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
